// File: rtl/risc_pkg.sv
// Shared defaults and types for the instruction-fetch/decode path.
package risc_pkg;

  localparam int unsigned INSTR_W_DEFAULT = 16;
  localparam int unsigned DEPTH_DEFAULT   = 4;

  typedef logic [INSTR_W_DEFAULT-1:0] instr_t;

endpackage

// File: rtl/iq_storage.sv
// DEPTH x INSTR_W register array for the instruction queue.
// It has one synchronous write port and one asynchronous read port. Contents are not reset.
module iq_storage
  import risc_pkg::*;
#(
  parameter int unsigned INSTR_W = INSTR_W_DEFAULT,
  parameter int unsigned DEPTH   = DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [INSTR_W-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [INSTR_W-1:0]         rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_queue.sv
// DEPTH-entry instruction queue between fetch and decode. Valid/ready on both sides, synchronous flush.
// The output holds the last delivered instruction. The optional macro IQ_BYPASS_EN adds a same-cycle path from fetch to decode while the queue is empty.
module instr_queue
  import risc_pkg::*;
#(
  parameter int unsigned INSTR_W = INSTR_W_DEFAULT,
  parameter int unsigned DEPTH   = DEPTH_DEFAULT,
  parameter int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               fetch_valid,
  output logic               fetch_ready,
  input  logic [INSTR_W-1:0] I_fetch,
  output logic [INSTR_W-1:0] I_decode,
  output logic               decode_valid,
  input  logic               decode_ready,
  output logic [CNT_W-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]      rd_ptr_q;
  logic [AW-1:0]      wr_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [INSTR_W-1:0] hold_q;
  logic [INSTR_W-1:0] head_data;
  logic [INSTR_W-1:0] dec_data;
  logic               not_empty;
  logic               bypass;
  logic               push;
  logic               pop;
  logic               mem_pop;
  logic               we;

  assign not_empty   = (count_q != '0);
  assign fetch_ready = (count_q < CNT_W'(DEPTH));

`ifdef IQ_BYPASS_EN
  assign bypass = !not_empty && fetch_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign decode_valid = not_empty || bypass;
  assign push         = fetch_valid && fetch_ready;
  assign pop          = decode_valid && decode_ready;
  assign mem_pop      = pop && not_empty;
  // A bypassed instruction that is consumed in the same cycle never occupies a slot.
  assign we           = push && !flush && !(bypass && decode_ready);

  always_comb begin
    dec_data = hold_q;
    if (not_empty) begin
      dec_data = head_data;
    end else if (bypass) begin
      dec_data = I_fetch;
    end
  end

  assign I_decode = dec_data;
  assign count    = count_q;

  iq_storage #(
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH)
  ) u_storage (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr_q),
    .wdata (I_fetch),
    .raddr (rd_ptr_q),
    .rdata (head_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (we) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (mem_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else begin
      case ({we, mem_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Latching the displayed value on flush as well as on pop keeps I_decode unchanged once the queue empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else if (flush || pop) begin
      hold_q <= dec_data;
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Scoreboard bench for instr_queue: directed pushes feed an expected-order queue and a monitor checks each pop.
module tb_instr_queue;

  localparam int unsigned IW = 16;
  localparam int unsigned DP = 4;
  localparam int unsigned CW = $clog2(DP + 1);

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          fetch_valid;
  logic          fetch_ready;
  logic [IW-1:0] I_fetch;
  logic [IW-1:0] I_decode;
  logic          decode_valid;
  logic          decode_ready;
  logic [CW-1:0] count;

  int total = 0;
  int bad   = 0;
  logic [IW-1:0] exp_q[$];

  instr_queue #(
    .INSTR_W (IW),
    .DEPTH   (DP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .fetch_valid  (fetch_valid),
    .fetch_ready  (fetch_ready),
    .I_fetch      (I_fetch),
    .I_decode     (I_decode),
    .decode_valid (decode_valid),
    .decode_ready (decode_ready),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change at posedge+1; the monitor looks at the stable handshake on the negedge before it fires.
  always @(negedge clk) begin
    if (rst_n && !flush && decode_valid && decode_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected_pop: got %0h expected none", I_decode);
      end else begin
        chk("sb_order", {16'h0, I_decode}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [IW-1:0] d);
    fetch_valid = 1'b1;
    I_fetch     = d;
    exp_q.push_back(d);
    step();
    fetch_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; fetch_valid = 1'b0; I_fetch = '0; decode_ready = 1'b0;
    step();
    step();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(decode_valid), 32'd0);
    chk("rst_idec",  32'(I_decode), 32'd0);
    chk("rst_ready", 32'(fetch_ready), 32'd1);
    rst_n = 1'b1;
    step();

    // three back-to-back pushes, decoder stalled
    push_one(16'h1111);
    push_one(16'h2222);
    push_one(16'h3333);
    #1;
    chk("t1_count", 32'(count), 32'd3);
    chk("t1_valid", 32'(decode_valid), 32'd1);
    chk("t1_idec",  32'(I_decode), 32'h1111);

    // fill, refuse push while full (even alongside a pop)
    push_one(16'h4444);
    fetch_valid = 1'b1; I_fetch = 16'hAAAA;
    #1;
    chk("full_ready", 32'(fetch_ready), 32'd0);
    step();
    chk("full_count", 32'(count), 32'd4);
    decode_ready = 1'b1;
    #1;
    chk("full_ready_pop", 32'(fetch_ready), 32'd0);
    step();
    decode_ready = 1'b0;
    chk("after_pop_count", 32'(count), 32'd3);
    chk("after_pop_ready", 32'(fetch_ready), 32'd1);
    exp_q.push_back(16'hAAAA);
    step();
    fetch_valid = 1'b0;
    chk("refill_count", 32'(count), 32'd4);
    decode_ready = 1'b1;
    repeat (4) step();
    decode_ready = 1'b0;
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_idec", 32'(I_decode), 32'hAAAA);

    // steady push+pop at count=2, pointers wrap several times
    push_one(16'h0100);
    push_one(16'h0101);
    decode_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      fetch_valid = 1'b1;
      I_fetch     = 16'h0102 + 16'(i);
      exp_q.push_back(I_fetch);
      step();
      chk("pp_count", 32'(count), 32'd2);
    end
    fetch_valid = 1'b1; I_fetch = 16'h5A5A;
    exp_q.push_back(16'h5A5A);
    step();
    fetch_valid = 1'b0;
    step();
    step();
    chk("empty_count", 32'(count), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("idle_valid", 32'(decode_valid), 32'd0);
      chk("idle_hold", 32'(I_decode), 32'h5A5A);
      step();
    end
    decode_ready = 1'b0;

    // flush at count=3 with concurrent push and pop
    push_one(16'h0C01);
    push_one(16'h0C02);
    push_one(16'h0C03);
    flush = 1'b1; fetch_valid = 1'b1; I_fetch = 16'hBEEF; decode_ready = 1'b1;
    step();
    flush = 1'b0; fetch_valid = 1'b0; decode_ready = 1'b0;
    exp_q.delete();
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(decode_valid), 32'd0);
    chk("flush_idec",  32'(I_decode), 32'h0C01);
    step();
    chk("flush_count2", 32'(count), 32'd0);
    push_one(16'h0D0D);
    decode_ready = 1'b1;
    step();
    decode_ready = 1'b0;
    chk("post_flush_count", 32'(count), 32'd0);

    // asynchronous reset mid-stream
    push_one(16'h0E01);
    push_one(16'h0E02);
    chk("pre_rst_count", 32'(count), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_idec",  32'(I_decode), 32'd0);
    chk("arst_valid", 32'(decode_valid), 32'd0);
    step();
    rst_n = 1'b1;
    step();

`ifdef IQ_BYPASS_EN
    fetch_valid = 1'b1; I_fetch = 16'h1234; decode_ready = 1'b1;
    exp_q.push_back(16'h1234);
    #1;
    chk("byp_valid", 32'(decode_valid), 32'd1);
    chk("byp_idec",  32'(I_decode), 32'h1234);
    step();
    fetch_valid = 1'b0; decode_ready = 1'b0;
    #1;
    chk("byp_count", 32'(count), 32'd0);
    chk("byp_hold",  32'(I_decode), 32'h1234);
    chk("byp_valid_after", 32'(decode_valid), 32'd0);
`endif

    step();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
